// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: ALU control classes,
// the hard-wired zero register and the decoded control bundle.
package mips_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [REG_ADDR_W_DEF-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10,
    ALU_OP_RSVD  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_src;
    logic    reg_dst;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    branch:     1'b0,
    alu_src:    1'b0,
    reg_dst:    1'b0,
    alu_op:     ALU_OP_ADD
  };

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare: a valid load sitting in EX whose
// destination (rt) is read by the valid instruction currently in ID.
module load_use_detect
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  load_use_stall
);

  logic dest_nonzero;
  logic src_match;

  // $0 as a load destination can never produce a value worth waiting for.
  assign dest_nonzero   = (ex_rt != REG_ADDR_W'(REG_ZERO));
  assign src_match      = (ex_rt == id_rs) || (ex_rt == id_rt);
  assign load_use_stall = ex_valid && ex_mem_read && id_valid && dest_nonzero && src_match;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures decoded operands, immediate and control,
// applies stall (hold) and flush / load-use (bubble) rules.
module id_ex_register
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc_plus4,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm_ext,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [4:0]            id_shamt,
  input  logic                  id_reg_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_branch,
  input  logic                  id_alu_src,
  input  logic                  id_reg_dst,
  input  logic [1:0]            id_alu_op,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc_plus4,
  output logic [DATA_W-1:0]     ex_rs_data,
  output logic [DATA_W-1:0]     ex_rt_data,
  output logic [DATA_W-1:0]     ex_imm_ext,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [4:0]            ex_shamt,
  output logic                  ex_reg_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic                  ex_alu_src,
  output logic                  ex_reg_dst,
  output logic [1:0]            ex_alu_op,
  output logic                  load_use_stall
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  bubble;

  // Control is gated with id_valid so an empty ID slot can never write state.
  always_comb begin
    id_ctrl = CTRL_NOP;
    if (id_valid) begin
      id_ctrl.reg_write  = id_reg_write;
      id_ctrl.mem_to_reg = id_mem_to_reg;
      id_ctrl.mem_read   = id_mem_read;
      id_ctrl.mem_write  = id_mem_write;
      id_ctrl.branch     = id_branch;
      id_ctrl.alu_src    = id_alu_src;
      id_ctrl.reg_dst    = id_reg_dst;
      id_ctrl.alu_op     = alu_op_e'(id_alu_op);
    end
  end

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .ex_valid       (ex_valid),
    .ex_mem_read    (ex_ctrl.mem_read),
    .ex_rt          (ex_rt),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .load_use_stall (load_use_stall)
  );

  assign bubble = flush || load_use_stall;

  // Priority: reset, then stall (hold), then flush / load-use (bubble), then load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_pc_plus4 <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm_ext  <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_shamt    <= '0;
      ex_ctrl     <= CTRL_NOP;
    end else if (!stall) begin
      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_pc_plus4 <= '0;
        ex_rs_data  <= '0;
        ex_rt_data  <= '0;
        ex_imm_ext  <= '0;
        ex_rs       <= '0;
        ex_rt       <= '0;
        ex_rd       <= '0;
        ex_shamt    <= '0;
        ex_ctrl     <= CTRL_NOP;
      end else begin
        ex_valid    <= id_valid;
        ex_pc_plus4 <= id_pc_plus4;
        ex_rs_data  <= id_rs_data;
        ex_rt_data  <= id_rt_data;
        ex_imm_ext  <= id_imm_ext;
        ex_rs       <= id_rs;
        ex_rt       <= id_rt;
        ex_rd       <= id_rd;
        ex_shamt    <= id_shamt;
        ex_ctrl     <= id_ctrl;
      end
    end
  end

  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_branch     = ex_ctrl.branch;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_reg_dst    = ex_ctrl.reg_dst;
  assign ex_alu_op     = ex_ctrl.alu_op;

endmodule

// File: doc/id_ex_register.md
Name: id_ex_register

Overview:
- Pipeline register between the decode stage (register file, sign extender, control unit) and the execute stage of the 5-stage MIPS core.
- Captures the decoded operands, the 32-bit sign-extended immediate and the control bundle.
- Applies hold (stall) and bubble (flush / load-use) rules.
- Detects load-use hazards and raises a stall request toward the PC and IF/ID.

Parameters:
- DATA_W, 32, width of the PC, operand and immediate datapath.
- REG_ADDR_W, 5, register specifier width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  downstream hold; EX does not advance this cycle.
- flush  input  1  branch/jump taken; squash the instruction in ID.
- id_valid  input  1  ID holds a real instruction.
- id_pc_plus4  input  DATA_W  PC+4 of the ID instruction.
- id_rs_data  input  DATA_W  register file read port A.
- id_rt_data  input  DATA_W  register file read port B.
- id_imm_ext  input  DATA_W  sign-extended immediate from the extension unit.
- id_rs, id_rt, id_rd  input  REG_ADDR_W each  register specifiers.
- id_shamt  input  5  shift amount field.
- id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst  input  1 each  control bits.
- id_alu_op  input  2  ALU control class.
- ex_*  output  widths as the matching id_* inputs  registered copies, including ex_valid.
- load_use_stall  output  1  combinational stall request to the PC and IF/ID.

Behaviour:
- Reset (async, active-high): every ex_* output goes to 0 immediately and stays 0 while reset is high. load_use_stall = 0 during reset.
- Latency is one clock; all ex_* outputs are registered.
- load_use_stall = ex_valid & ex_mem_read & id_valid & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
  - Purely combinational from registered EX state plus the ID inputs.
- Per-edge priority, highest first:
  1. reset
  2. stall: hold all ex_* unchanged.
  3. flush: load a bubble.
  4. load_use_stall: load a bubble.
  5. otherwise load all id_* into ex_*, with ex_valid = id_valid.
- Bubble: ex_valid = 0, all control bits and ex_alu_op = 0, data and specifier fields = 0 (deterministic, no architectural side effects).
- When stall and flush arrive together, stall wins and the register holds. The flush source keeps flush asserted until stall drops.
- During stall, load_use_stall may still assert. The EX contents do not change, so it stays consistent on the next cycle.
- When id_valid = 0 and no stall, the register loads a bubble-equivalent: ex_valid = 0 and control bits forced to 0.
- Control bits are gated with id_valid, so an invalid ID slot never writes.
- No arithmetic is performed; id_imm_ext passes through unchanged at full DATA_W.
- Register $0 as a load destination never triggers a hazard.

Decomposition:
- Shared package mips_pkg holds:
  - the ALU_OP encodings (2-bit: 00 add, 01 sub, 10 funct, 11 reserved);
  - the REG_ZERO constant;
  - a ctrl bundle field list (reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst, alu_op).
- One natural sub-module: load_use_detect, a combinational hazard compare instantiated inside id_ex_register.

Test Plan:
- Normal flow: id_valid=1, id_imm_ext=0xFFFF8000, id_rs_data=0x12, id_reg_write=1, no stall/flush -> next edge ex_imm_ext=0xFFFF8000, ex_rs_data=0x12, ex_reg_write=1, ex_valid=1.
- Load-use: EX holds lw with ex_rt=5, ex_mem_read=1; ID presents add with id_rs=5 -> load_use_stall=1 same cycle; next edge ex_valid=0, all control 0; load_use_stall then drops.
- $0 destination: EX lw with ex_rt=0, ID uses rs=0 -> load_use_stall=0; ID instruction loads normally.
- Stall vs flush: stall=1 and flush=1 together with EX holding pc_plus4=0x40 -> ex_* unchanged (ex_pc_plus4=0x40); drop stall, keep flush -> bubble loaded.
- Async reset mid-operation: assert reset between clock edges while ex_valid=1, ex_mem_write=1 -> all ex_* go to 0 without waiting for an edge; after release, first edge loads ID normally.
- Invalid slot: id_valid=0 with id_mem_write=1 -> ex_valid=0, ex_mem_write=0.
